// File: rtl/pw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pw_pkg
//  Description : Shared types and constants for the password checker slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package pw_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } pw_state_t;

    // Width of one password byte on the receive stream
    localparam int c_byte_w = 8;

    // Default entry length and consecutive-failure limit
    localparam int c_default_pw_bytes     = 4;
    localparam int c_default_max_attempts = 3;

endpackage : pw_pkg
`default_nettype wire

// File: rtl/pw_lockout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pw_lockout_timer
//  Description : Loadable down-counter with a done flag (count == 0). Holds
//                at zero once exhausted; load takes priority over counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module pw_lockout_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    // Reload on request, otherwise count down while enabled and not exhausted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule : pw_lockout_timer
`default_nettype wire

// File: rtl/password_checker.sv
`default_nettype none
// ============================================================================
//  Module      : password_checker
//  Description : Collects PW_BYTES password bytes, compares them in constant
//                time against a provisioned reference, pulses auth_ok or
//                auth_fail, and enforces a timed lockout after MAX_ATTEMPTS
//                consecutive failures. Only a 1-bit mismatch flag is kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module password_checker
    import pw_pkg::*;
#(
    parameter int PW_BYTES       = c_default_pw_bytes,
    parameter int MAX_ATTEMPTS   = c_default_max_attempts,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              rx_valid,
    input  logic [c_byte_w-1:0]               rx_byte,
    input  logic                              ref_load,
    input  logic [c_byte_w*PW_BYTES-1:0]      ref_value,
    output logic                              auth_ok,
    output logic                              auth_fail,
    output logic                              locked,
    output logic                              busy,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);

    localparam int c_idx_w = $clog2(PW_BYTES);
    localparam int c_att_w = $clog2(MAX_ATTEMPTS + 1);
    localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_lk_w  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PW_BYTES - 1);
    localparam logic [c_att_w-1:0] c_att_max  = c_att_w'(MAX_ATTEMPTS);
    // Timers count down to zero inclusive, so load one less than the span
    localparam logic [c_to_w-1:0]  c_to_load  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_lk_w-1:0]  c_lk_load  = c_lk_w'(LOCKOUT_CYCLES - 1);

    pw_state_t                     r_state;
    logic [c_byte_w*PW_BYTES-1:0]  r_ref;
    logic [c_idx_w-1:0]            r_idx;
    logic                          r_mism;
    logic [c_att_w-1:0]            r_attempts;
    logic                          r_auth_ok;
    logic                          r_auth_fail;

    logic [c_byte_w-1:0]           w_ref_bytes [PW_BYTES];
    logic                          w_byte_mism;
    logic                          w_mism_next;
    logic                          w_accept;
    logic                          w_timeout_done;
    logic                          w_lockout_done;

    // Byte-indexed view of the reference register (byte 0 in the low bits)
    for (genvar g = 0; g < PW_BYTES; g++) begin : g_ref_bytes
        assign w_ref_bytes[g] = r_ref[g*c_byte_w +: c_byte_w];
    end

    // idx is held at 0 in IDLE, so the first byte always meets ref byte 0.
    // The whole entry is always consumed; the flag only ever accumulates.
    assign w_byte_mism = (rx_byte != w_ref_bytes[r_idx]);
    assign w_mism_next = r_mism | w_byte_mism;
    assign w_accept    = rx_valid && ((r_state == ST_IDLE) || (r_state == ST_COLLECT));

    // Inter-byte gap timer: restarted by every accepted byte, runs only while collecting
    pw_lockout_timer #(
        .WIDTH      (c_to_w)
    ) u_timeout_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_accept),
        .load_value (c_to_load),
        .enable     ((r_state == ST_COLLECT) && !rx_valid),
        .done       (w_timeout_done)
    );

    // Lockout timer: armed during the final failing CHECK cycle
    pw_lockout_timer #(
        .WIDTH      (c_lk_w)
    ) u_lockout_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       ((r_state == ST_CHECK) && (r_attempts == '0)),
        .load_value (c_lk_load),
        .enable     (r_state == ST_LOCKED),
        .done       (w_lockout_done)
    );

    // Main FSM: entry collection, result pulses, attempt counting and lockout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ref       <= '0;
            r_idx       <= '0;
            r_mism      <= 1'b0;
            r_attempts  <= c_att_max;
            r_auth_ok   <= 1'b0;
            r_auth_fail <= 1'b0;
        end else begin
            r_auth_ok   <= 1'b0;
            r_auth_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A byte arriving with ref_load still sees the old reference
                    if (ref_load) begin
                        r_ref <= ref_value;
                    end
                    if (rx_valid) begin
                        r_mism  <= w_byte_mism;
                        r_idx   <= c_idx_w'(1);
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (rx_valid) begin
                        r_mism <= w_mism_next;
                        if (r_idx == c_last_idx) begin
                            // Result is registered here so pass and fail share one latency
                            r_idx   <= '0;
                            r_state <= ST_CHECK;
                            if (w_mism_next) begin
                                r_auth_fail <= 1'b1;
                                r_attempts  <= r_attempts - c_att_w'(1);
                            end else begin
                                r_auth_ok  <= 1'b1;
                                r_attempts <= c_att_max;
                            end
                        end else begin
                            r_idx <= r_idx + c_idx_w'(1);
                        end
                    end else if (w_timeout_done) begin
                        // Abandoned entry: silent, attempts untouched
                        r_idx   <= '0;
                        r_mism  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    r_mism  <= 1'b0;
                    r_state <= (r_attempts == '0) ? ST_LOCKED : ST_IDLE;
                end
                ST_LOCKED: begin
                    if (w_lockout_done) begin
                        r_attempts <= c_att_max;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign auth_ok       = r_auth_ok;
    assign auth_fail     = r_auth_fail;
    assign locked        = (r_state == ST_LOCKED);
    assign busy          = (r_state == ST_COLLECT);
    assign attempts_left = r_attempts;

endmodule : password_checker
`default_nettype wire

// File: tb/tb_password_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_password_checker
//  Description : Directed self-checking bench for password_checker. Expected
//                results are queued as entries are sent and matched against
//                the auth pulses (kind, cycle and attempts_left).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_password_checker;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        rx_valid  = 1'b0;
    logic [7:0]  rx_byte   = 8'h00;
    logic        ref_load  = 1'b0;
    logic [31:0] ref_value = 32'h0;
    logic        auth_ok;
    logic        auth_fail;
    logic        locked;
    logic        busy;
    logic [1:0]  attempts_left;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        bit          ok;
        int unsigned cyc;
        logic [1:0]  att;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    logic [31:0] pw_good = 32'hA1B2C3D4;
    logic [31:0] pw_bad  = 32'hA1B2C300;

    password_checker u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .ref_load      (ref_load),
        .ref_value     (ref_value),
        .auth_ok       (auth_ok),
        .auth_fail     (auth_fail),
        .locked        (locked),
        .busy          (busy),
        .attempts_left (attempts_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one clock; returns #1 after the sampling edge
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic entry_bytes(input logic [31:0] pw);
        for (int i = 0; i < 4; i++) send(pw[i*8 +: 8]);
    endtask

    // Called right after the last byte's edge: the pulse belongs to this cycle
    task automatic push_exp(input bit ok, input logic [1:0] att);
        exp_t e;
        e.ok  = ok;
        e.cyc = cyc;
        e.att = att;
        sb.push_back(e);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_auth_ok"},   {31'd0, auth_ok},   0);
        check({tag, "_auth_fail"}, {31'd0, auth_fail}, 0);
        check({tag, "_locked"},    {31'd0, locked},    0);
        check({tag, "_busy"},      {31'd0, busy},      0);
        check({tag, "_attempts"},  {30'd0, attempts_left}, 3);
    endtask

    // Scoreboard consumer: every pulse must match the oldest queued entry
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (auth_ok === 1'b1 || auth_fail === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, auth_ok, auth_fail}, 0);
            end else begin
                e_mon = sb.pop_front();
                check("pulse_ok",       {31'd0, auth_ok},   {31'd0, e_mon.ok});
                check("pulse_fail",     {31'd0, auth_fail}, {31'd0, !e_mon.ok});
                check("pulse_cycle",    cyc, e_mon.cyc);
                check("pulse_attempts", {30'd0, attempts_left}, {30'd0, e_mon.att});
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state, during and after reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        // Reference is zero after reset
        entry_bytes(32'h0);
        push_exp(1'b1, 2'd3);
        drain();

        // Load reference, correct entry
        ref_load  = 1'b1;
        ref_value = pw_good;
        @(posedge clk);
        #1;
        ref_load  = 1'b0;
        entry_bytes(pw_good);
        push_exp(1'b1, 2'd3);
        drain();

        // First byte wrong; a byte during CHECK must be dropped
        entry_bytes(pw_bad);
        push_exp(1'b0, 2'd2);
        send(8'hD4);
        drain();
        entry_bytes(pw_good);
        push_exp(1'b1, 2'd3);
        drain();

        // Lockout after three consecutive failures
        entry_bytes(pw_bad);
        push_exp(1'b0, 2'd2);
        drain();
        entry_bytes(pw_bad);
        push_exp(1'b0, 2'd1);
        drain();
        entry_bytes(pw_bad);
        push_exp(1'b0, 2'd0);
        @(negedge clk);
        check("locked_during_check", {31'd0, locked}, 0);
        @(negedge clk);
        check("locked_rise", {31'd0, locked}, 1);
        n = 0;
        while (locked === 1'b1 && n < 2000) begin
            rx_valid = (n < 8);
            rx_byte  = pw_good[(n % 4)*8 +: 8];
            n++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("lockout_length", n, 1024);
        check("attempts_after_lockout", {30'd0, attempts_left}, 3);
        check("sb_empty_after_lockout", sb.size(), 0);
        @(posedge clk);
        #1;
        entry_bytes(pw_good);
        push_exp(1'b1, 2'd3);
        drain();

        // Timeout of a partial entry leaves attempts_left alone
        entry_bytes(pw_bad);
        push_exp(1'b0, 2'd2);
        drain();
        send(8'hD4);
        send(8'hC3);
        repeat (255) @(posedge clk);
        #1;
        check("busy_before_timeout", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        check("busy_after_timeout", {31'd0, busy}, 0);
        check("attempts_after_timeout", {30'd0, attempts_left}, 2);
        entry_bytes(pw_good);
        push_exp(1'b1, 2'd3);
        drain();

        // Byte arriving on the final timeout cycle is accepted
        send(8'hD4);
        repeat (255) @(posedge clk);
        #1;
        send(8'hC3);
        send(8'hB2);
        send(8'hA1);
        push_exp(1'b1, 2'd3);
        drain();

        // ref_load during COLLECT is ignored
        send(8'hD4);
        ref_load  = 1'b1;
        ref_value = 32'hFFFFFFFF;
        send(8'hC3);
        ref_load  = 1'b0;
        send(8'hB2);
        send(8'hA1);
        push_exp(1'b1, 2'd3);
        drain();
        entry_bytes(pw_good);
        push_exp(1'b1, 2'd3);
        drain();

        // ref_load with the first byte: byte 0 uses old ref, the rest the new one
        ref_load  = 1'b1;
        ref_value = 32'h11223344;
        send(8'hD4);
        ref_load  = 1'b0;
        send(8'h33);
        send(8'h22);
        send(8'h11);
        push_exp(1'b1, 2'd3);
        drain();

        // Reset in the middle of an entry
        entry_bytes(32'h11223300);
        push_exp(1'b0, 2'd2);
        drain();
        send(8'h44);
        send(8'h33);
        check("busy_mid_entry", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_collect");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset during lockout (reference is zero again)
        for (int k = 0; k < 3; k++) begin
            entry_bytes(32'h00000001);
            push_exp(1'b0, 2'(2 - k));
            drain();
        end
        repeat (20) @(posedge clk);
        #1;
        check("locked_before_reset", {31'd0, locked}, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_locked");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        entry_bytes(32'h0);
        push_exp(1'b1, 2'd3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_password_checker
`default_nettype wire

// File: doc/password_checker.md
# password_checker

Downstream consumer of the 8-bit password byte stream produced by the password transmit stage. It collects PW_BYTES bytes, compares them in constant time against a provisioned reference value, and emits a one-cycle pass or fail pulse. It also enforces a consecutive-failure limit with a timed lockout. Only a 1-bit mismatch accumulator is stored; received password bytes are never retained.

## Interface
- PW_BYTES, 4, number of bytes per password entry (≥2)
- MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (≥1)
- LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (≥2)
- TIMEOUT_CYCLES, 256, maximum idle gap between bytes within one entry
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  rx_byte is valid this cycle
- rx_byte  in  8  password byte from the transmit stage
- ref_load  in  1  pulse: load ref_value as the reference password
- ref_value  in  8*PW_BYTES  reference password; byte 0 = bits [7:0], compared first
- auth_ok  out  1  one-cycle pulse: entry matched
- auth_fail  out  1  one-cycle pulse: entry mismatched
- locked  out  1  lockout active
- busy  out  1  entry in progress (COLLECT state)
- attempts_left  out  $clog2(MAX_ATTEMPTS+1)  remaining attempts before lockout

## Operation
- States: IDLE, COLLECT, CHECK, LOCKED.
- IDLE:
  - rx_valid → accept byte 0, mism = (rx_byte != ref[0]), idx = 1, go to COLLECT.
  - ref_load is honoured only in IDLE. In all other states it is ignored.
- COLLECT:
  - Each rx_valid → mism |= (rx_byte != ref[idx]), idx++.
  - On the PW_BYTES-th byte → go to CHECK.
  - No early exit on mismatch: every entry consumes exactly PW_BYTES bytes.
- Timeout:
  - In COLLECT, the gap counter resets on each accepted byte.
  - When TIMEOUT_CYCLES consecutive cycles pass without rx_valid → return to IDLE and clear idx and mism.
  - A timeout produces no pulse and does not change attempts_left.
- CHECK (one cycle):
  - mism = 0 → auth_ok, attempts_left = MAX_ATTEMPTS, go to IDLE.
  - mism = 1 → auth_fail, attempts_left decrements.
    - If attempts_left reaches 0 → go to LOCKED and load the lockout counter with LOCKOUT_CYCLES-1.
    - Otherwise → go to IDLE.
- LOCKED:
  - locked = 1. The counter decrements each cycle.
  - When the counter reaches 0 → go to IDLE with attempts_left = MAX_ATTEMPTS.
- rx_valid in CHECK or LOCKED is dropped. Dropped bytes do not start an entry.
- mism is cleared on every transition into IDLE.

## Timing
- Reset values:
  - State IDLE.
  - auth_ok = 0, auth_fail = 0, locked = 0, busy = 0.
  - attempts_left = MAX_ATTEMPTS.
  - Reference = all zeros.
  - idx, mism and all counters = 0.
- Latency: last byte accepted on cycle N → CHECK on cycle N+1. auth_ok/auth_fail are driven from the registered state decode and are high during cycle N+1.
- Result latency is PW_BYTES-independent and identical for pass and fail, so there is no timing side channel.
- The earliest next entry byte is accepted on cycle N+2 (IDLE).
- locked rises on the cycle after the final auth_fail. It stays high for exactly LOCKOUT_CYCLES cycles.
- attempts_left updates in the same cycle as the pulse.
- busy = (state == COLLECT).
- On reset mid-entry or mid-lockout, the reset values above apply immediately.
- The reference is cleared by reset, so a reload is required after reset.
- Simultaneous ref_load and rx_valid in IDLE:
  - The new reference loads on that cycle.
  - The accepted byte compares against the old reference.
  - All later bytes of that entry compare against the new reference.
- Simultaneous timeout expiry and rx_valid: the byte is accepted and the timeout does not fire.

## Structure
- Shared package pw_pkg:
  - State enum (IDLE/COLLECT/CHECK/LOCKED).
  - Byte width constant (8).
  - Default PW_BYTES and MAX_ATTEMPTS.
- A single sub-module, pw_lockout_timer, is natural: a loadable down-counter with a done flag. It is reused for both the inter-byte timeout and the lockout counter.
- The top level holds the FSM, idx, the mism accumulator, the attempt counter and the reference register.

## Test plan
- Correct entry:
  - Stimulus: load ref 0xA1B2C3D4; send 0xD4, 0xC3, 0xB2, 0xA1 on consecutive cycles.
  - Response: auth_ok on the cycle after 0xA1; attempts_left = 3.
- Constant-time fail:
  - Stimulus: first byte wrong, 0x00, 0xC3, 0xB2, 0xA1.
  - Response: auth_fail at the same cycle offset as the pass case; attempts_left = 2.
- Lockout:
  - Stimulus: 3 wrong entries.
  - Response: locked = 1 for exactly 1024 cycles; bytes sent during lockout produce no pulse; after lockout, attempts_left = 3 and a correct entry yields auth_ok.
- Timeout:
  - Stimulus: send 2 bytes, wait 256 cycles, then send a full correct entry.
  - Response: no pulse for the partial entry, then auth_ok; attempts_left unchanged.
- Reset mid-COLLECT and mid-LOCKED:
  - Stimulus: assert reset_n low in each state.
  - Response: all outputs return to reset values immediately; attempts_left = 3.
- ref_load outside IDLE:
  - Stimulus: pulse ref_load with 0xFFFFFFFF during COLLECT.
  - Response: ignored; the entry still checks against 0xA1B2C3D4.
